idx2cloud_arbiter: RTL and testbench
====================================

# idx2cloud_arbiter

Shares one `Idx2Cloud` back-projection pipeline between two point requesters: requester 0 is the current-frame stream and requester 1 is the previous-frame stream. It arbitrates round-robin and drops zero-depth samples before issue. It tags each issued sample and tracks the fixed datapath latency with a tag shift register. Results are returned through a credit-protected output FIFO with valid/ready, so the `Idx2Cloud` pipeline, which has no stall, can never overflow downstream.

## Interface
Parameters:
- `LATENCY`, 4, cycles from `o_i2c_valid` to `i_i2c_valid` (the `Idx2Cloud` latency).
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, ≥ `LATENCY`+1.
- `CNT_BW`, `$clog2(FIFO_DEPTH+1)`, width of the occupancy and credit counters.

Ports (widths come from `RgbdVoConfigPk`):
- `i_clk` in 1: single clock; all logic is on the rising edge.
- `i_rst_n` in 1: synchronous, active-low reset.
- `i_req_valid` in 2: per-requester sample valid.
- `o_req_ready` out 2: per-requester accept.
- `i_req0_idx_x`, `i_req1_idx_x` in `H_SIZE_BW`: pixel column.
- `i_req0_idx_y`, `i_req1_idx_y` in `V_SIZE_BW`: pixel row.
- `i_req0_depth`, `i_req1_depth` in `DATA_DEPTH_BW`: depth; 0 means invalid.
- `o_i2c_valid` out 1: drives `Idx2Cloud` `i_valid`.
- `o_i2c_idx_x` out `H_SIZE_BW`, `o_i2c_idx_y` out `V_SIZE_BW`, `o_i2c_depth` out `DATA_DEPTH_BW`: `Idx2Cloud` inputs.
- `i_i2c_valid` in 1: `Idx2Cloud` `o_valid`.
- `i_i2c_cloud_x`, `i_i2c_cloud_y`, `i_i2c_cloud_z` in `CLOUD_BW`: `Idx2Cloud` results.
- `o_valid` out 1, `i_ready` in 1: output handshake.
- `o_tag` out 1: requester index of the output point.
- `o_cloud_x`, `o_cloud_y`, `o_cloud_z` out `CLOUD_BW`: output point.
- `o_drop_cnt` out 16: zero-depth drops, saturating at 16'hFFFF.
- `o_busy` out 1: asserted when `inflight`≠0, the FIFO is non-empty, or the issue register is valid.
- `o_err` out 1: sticky latency-mismatch flag.

## Operation
- Credit rule: `credit_ok` = (`fifo_cnt` + `inflight`) < `FIFO_DEPTH`.
- `inflight` counts accepted non-zero samples that have not yet been written into the FIFO; this includes the sample in the issue register.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester pointed to by `rr_ptr` wins.
  - `o_req_ready[k]` = `credit_ok` & win_k. Ready depends on valid; valid never depends on ready.
  - An accept (fire) on requester k sets `rr_ptr` to the other requester (!k).
  - `rr_ptr` resets to 0.
- Accept handling:
  - Depth ≠ 0: load the issue register with {idx_x, idx_y, depth, tag=k}, set issue-valid, and increment `inflight`.
  - Depth = 0: the sample is consumed but not issued. `o_drop_cnt` increments, `inflight` is unchanged, and `rr_ptr` still rotates.
- Issue register drives `o_i2c_*`. If there is no accept in a cycle, issue-valid clears next cycle and the data outputs hold their last value.
- Tag pipeline: a `LATENCY`-deep shift register of {valid, tag} follows `o_i2c_valid`.
- Return path: on `i_i2c_valid`, push {tag-pipe tag, x, y, z} into the FIFO and decrement `inflight`.
  - If `i_i2c_valid` ≠ tag-pipe valid, set `o_err` (cleared only by reset).
  - On that mismatch, if the tag pipe is not valid, the result is still pushed with tag 0.
- Output FIFO:
  - `o_valid` = non-empty; the head is shown combinationally from registered storage.
  - Pop on `o_valid` & `i_ready`.
  - Simultaneous push and pop leaves `fifo_cnt` unchanged; pointers wrap modulo `FIFO_DEPTH`.
- Same-cycle counter events: an accept increment and a return decrement of `inflight` in the same cycle leave it unchanged. Push and pop in the same cycle leave `fifo_cnt` unchanged.
- Overflow cannot occur by construction. A push to a full FIFO is not required to be handled beyond setting `o_err`.

## Timing
- Reset (`i_rst_n`=0 at an edge) clears:
  - FIFO pointers and `fifo_cnt`, `inflight`, the tag pipe, issue-valid, `rr_ptr`, `o_drop_cnt`, `o_err`.
- All outputs are 0 after reset. `o_req_ready` is forced to 0 while `i_rst_n`=0.
- Reset mid-operation discards all in-flight and buffered points. Results `Idx2Cloud` returns after reset are ignored for `LATENCY` cycles (masked while the tag pipe is empty and a post-reset guard counter is < `LATENCY`). They raise no `o_err`.
- Latency:
  - Accept edge to `o_i2c_valid`: 1 cycle.
  - `o_i2c_valid` to `i_i2c_valid`: `LATENCY` cycles.
  - Push to `o_valid`: 1 cycle.
  - Minimum accept-to-`o_valid` = `LATENCY`+2 = 6.
- Throughput: 1 sample/cycle sustained while `i_ready`=1.

## Test plan
- Single requester: req0 sends 20 samples (depth 100..119), `i_ready`=1 → 20 outputs with tag 0, in order; first `o_valid` 6 cycles after first accept; `o_err`=0.
- Both requesters held valid: accepts alternate 0,1,0,1,…; output tags alternate; equal counts after 16 accepts.
- Backpressure: `i_ready`=0 with continuous valids → exactly `FIFO_DEPTH`=8 accepts, then `o_req_ready`=0; release → all 8 drain in order, no loss.
- Zero depth: req1 sends depths 0,5,0,7 → `o_drop_cnt`=2; 2 outputs (depths 5,7) with tag 1; `rr_ptr` still alternates.
- Error/reset: inject a spurious `i_i2c_valid` → `o_err`=1 sticky. Assert `i_rst_n`=0 with 3 in flight → all counters 0, `o_valid`=0, no outputs and no `o_err` from the stale returns.

Source files
------------

// File: rtl/idx2cloud_arbiter.sv
// idx2cloud_arbiter: round-robin sharing of one fixed-latency Idx2Cloud pipeline between two
// point requesters, with zero-depth drop, tag tracking and a credit-protected output FIFO.
module idx2cloud_arbiter #(
    parameter int unsigned LATENCY       = 4,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned CNT_BW        = $clog2(FIFO_DEPTH + 1),
    parameter int unsigned H_SIZE_BW     = 10,
    parameter int unsigned V_SIZE_BW     = 9,
    parameter int unsigned DATA_DEPTH_BW = 16,
    parameter int unsigned CLOUD_BW      = 24
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [1:0]               i_req_valid,
    output logic [1:0]               o_req_ready,
    input  logic [H_SIZE_BW-1:0]     i_req0_idx_x,
    input  logic [V_SIZE_BW-1:0]     i_req0_idx_y,
    input  logic [DATA_DEPTH_BW-1:0] i_req0_depth,
    input  logic [H_SIZE_BW-1:0]     i_req1_idx_x,
    input  logic [V_SIZE_BW-1:0]     i_req1_idx_y,
    input  logic [DATA_DEPTH_BW-1:0] i_req1_depth,
    output logic                     o_i2c_valid,
    output logic [H_SIZE_BW-1:0]     o_i2c_idx_x,
    output logic [V_SIZE_BW-1:0]     o_i2c_idx_y,
    output logic [DATA_DEPTH_BW-1:0] o_i2c_depth,
    input  logic                     i_i2c_valid,
    input  logic [CLOUD_BW-1:0]      i_i2c_cloud_x,
    input  logic [CLOUD_BW-1:0]      i_i2c_cloud_y,
    input  logic [CLOUD_BW-1:0]      i_i2c_cloud_z,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_tag,
    output logic [CLOUD_BW-1:0]      o_cloud_x,
    output logic [CLOUD_BW-1:0]      o_cloud_y,
    output logic [CLOUD_BW-1:0]      o_cloud_z,
    output logic [15:0]              o_drop_cnt,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int unsigned PTR_BW   = $clog2(FIFO_DEPTH);
    localparam int unsigned GUARD_BW = $clog2(LATENCY + 1);
    localparam int unsigned SUM_BW   = CNT_BW + 1;

    typedef struct packed {
        logic                tag;
        logic [CLOUD_BW-1:0] x;
        logic [CLOUD_BW-1:0] y;
        logic [CLOUD_BW-1:0] z;
    } fifo_entry_t;

    logic                     rr_ptr_q, rr_ptr_d;
    logic                     iss_vld_q, iss_vld_d;
    logic                     iss_tag_q, iss_tag_d;
    logic [H_SIZE_BW-1:0]     iss_x_q, iss_x_d;
    logic [V_SIZE_BW-1:0]     iss_y_q, iss_y_d;
    logic [DATA_DEPTH_BW-1:0] iss_d_q, iss_d_d;
    logic [CNT_BW-1:0]        inflight_q, inflight_d;
    logic [CNT_BW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [PTR_BW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_BW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LATENCY-1:0]       pipe_vld_q;
    logic [LATENCY-1:0]       pipe_tag_q;
    logic [GUARD_BW-1:0]      guard_q, guard_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;
    logic                     err_q, err_d;
    fifo_entry_t              mem_q [FIFO_DEPTH];

    logic [SUM_BW-1:0]        occupancy;
    logic                     credit_ok, win0, win1, fire, sel, acc_nz, issue;
    logic [H_SIZE_BW-1:0]     acc_x;
    logic [V_SIZE_BW-1:0]     acc_y;
    logic [DATA_DEPTH_BW-1:0] acc_d;
    logic                     mask_ret, ret_vld, ret_dec, ret_tag, ret_mismatch;
    logic                     fifo_full, pop, push, overflow;
    fifo_entry_t              head;

    // Arbitration: a lone requester wins, contention is resolved by rr_ptr.
    assign occupancy   = SUM_BW'(fifo_cnt_q) + SUM_BW'(inflight_q);
    assign credit_ok   = occupancy < SUM_BW'(FIFO_DEPTH);
    assign win0        = i_req_valid[0] & (~i_req_valid[1] | ~rr_ptr_q);
    assign win1        = i_req_valid[1] & (~i_req_valid[0] | rr_ptr_q);
    assign o_req_ready = {2{credit_ok & i_rst_n}} & {win1, win0};
    assign fire        = |o_req_ready;
    assign sel         = win1;
    assign acc_x       = sel ? i_req1_idx_x : i_req0_idx_x;
    assign acc_y       = sel ? i_req1_idx_y : i_req0_idx_y;
    assign acc_d       = sel ? i_req1_depth : i_req0_depth;
    assign acc_nz      = acc_d != '0;
    assign issue       = fire & acc_nz;

    // Stale returns right after reset are ignored until the guard expires or a tag enters.
    assign mask_ret     = ~|pipe_vld_q & (guard_q < GUARD_BW'(LATENCY));
    assign ret_vld      = i_i2c_valid & ~mask_ret;
    assign ret_dec      = ret_vld & (inflight_q != '0);
    assign ret_tag      = pipe_vld_q[LATENCY-1] & pipe_tag_q[LATENCY-1];
    assign ret_mismatch = ~mask_ret & (i_i2c_valid != pipe_vld_q[LATENCY-1]);

    assign fifo_full = fifo_cnt_q == CNT_BW'(FIFO_DEPTH);
    assign o_valid   = fifo_cnt_q != '0;
    assign pop       = o_valid & i_ready;
    assign push      = ret_vld & (~fifo_full | pop);
    assign overflow  = ret_vld & fifo_full & ~pop;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        iss_vld_d  = issue;
        iss_tag_d  = iss_tag_q;
        iss_x_d    = iss_x_q;
        iss_y_d    = iss_y_q;
        iss_d_d    = iss_d_q;
        inflight_d = inflight_q;
        fifo_cnt_d = fifo_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        guard_d    = guard_q;
        drop_cnt_d = drop_cnt_q;
        err_d      = err_q;

        if (fire) begin
            rr_ptr_d = ~sel;
        end
        if (issue) begin
            iss_tag_d = sel;
            iss_x_d   = acc_x;
            iss_y_d   = acc_y;
            iss_d_d   = acc_d;
        end
        if (fire && !acc_nz && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        case ({issue, ret_dec})
            2'b10:   inflight_d = inflight_q + CNT_BW'(1);
            2'b01:   inflight_d = inflight_q - CNT_BW'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_BW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_BW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_BW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BW'(1);
        end
        if (guard_q != GUARD_BW'(LATENCY)) begin
            guard_d = guard_q + GUARD_BW'(1);
        end
        if (ret_mismatch || overflow) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr_q   <= 1'b0;
            iss_vld_q  <= 1'b0;
            iss_tag_q  <= 1'b0;
            iss_x_q    <= '0;
            iss_y_q    <= '0;
            iss_d_q    <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pipe_vld_q <= '0;
            pipe_tag_q <= '0;
            guard_q    <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            iss_vld_q  <= iss_vld_d;
            iss_tag_q  <= iss_tag_d;
            iss_x_q    <= iss_x_d;
            iss_y_q    <= iss_y_d;
            iss_d_q    <= iss_d_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            guard_q    <= guard_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
            // Tag pipe mirrors the Idx2Cloud latency.
            pipe_vld_q[0] <= iss_vld_q;
            pipe_tag_q[0] <= iss_tag_q;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    // Storage needs no reset; the head is gated by o_valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{tag: ret_tag, x: i_i2c_cloud_x, y: i_i2c_cloud_y, z: i_i2c_cloud_z};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign o_tag       = o_valid & head.tag;
    assign o_cloud_x   = o_valid ? head.x : '0;
    assign o_cloud_y   = o_valid ? head.y : '0;
    assign o_cloud_z   = o_valid ? head.z : '0;
    assign o_i2c_valid = iss_vld_q;
    assign o_i2c_idx_x = iss_x_q;
    assign o_i2c_idx_y = iss_y_q;
    assign o_i2c_depth = iss_d_q;
    assign o_drop_cnt  = drop_cnt_q;
    assign o_err       = err_q;
    assign o_busy      = (inflight_q != '0) | o_valid | iss_vld_q;

endmodule

// File: tb/tb_idx2cloud_arbiter.sv
// tb_idx2cloud_arbiter: directed and random traffic against a transaction-level reference of
// the arbiter, with a behavioural fixed-latency Idx2Cloud stand-in on the return side.
module tb_idx2cloud_arbiter;

    localparam int unsigned LATENCY    = 4;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned HW = 10;
    localparam int unsigned VW = 9;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 24;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [CW-1:0] z;
    } cloud_t;

    typedef struct packed {
        logic [HW-1:0] x;
        logic [VW-1:0] y;
        logic [DW-1:0] d;
    } sample_t;

    typedef struct {
        logic   tag;
        cloud_t c;
        int     t_vis;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = '0;
    logic [1:0]    req_ready;
    logic [HW-1:0] r0_x = '0, r1_x = '0;
    logic [VW-1:0] r0_y = '0, r1_y = '0;
    logic [DW-1:0] r0_d = '0, r1_d = '0;
    logic          i2c_valid;
    logic [HW-1:0] i2c_x;
    logic [VW-1:0] i2c_y;
    logic [DW-1:0] i2c_d;
    logic          ret_valid;
    cloud_t        ret_c;
    logic          out_valid;
    logic          rdy_in = 1'b0;
    logic          out_tag;
    logic [CW-1:0] out_x, out_y, out_z;
    logic [15:0]   drop_cnt;
    logic          busy;
    logic          err;

    logic          inj = 1'b0;
    cloud_t        inj_c = '0;

    always #5 clk = ~clk;

    idx2cloud_arbiter #(
        .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH),
        .H_SIZE_BW(HW), .V_SIZE_BW(VW), .DATA_DEPTH_BW(DW), .CLOUD_BW(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req0_idx_x(r0_x), .i_req0_idx_y(r0_y), .i_req0_depth(r0_d),
        .i_req1_idx_x(r1_x), .i_req1_idx_y(r1_y), .i_req1_depth(r1_d),
        .o_i2c_valid(i2c_valid), .o_i2c_idx_x(i2c_x), .o_i2c_idx_y(i2c_y), .o_i2c_depth(i2c_d),
        .i_i2c_valid(ret_valid),
        .i_i2c_cloud_x(ret_c.x), .i_i2c_cloud_y(ret_c.y), .i_i2c_cloud_z(ret_c.z),
        .o_valid(out_valid), .i_ready(rdy_in), .o_tag(out_tag),
        .o_cloud_x(out_x), .o_cloud_y(out_y), .o_cloud_z(out_z),
        .o_drop_cnt(drop_cnt), .o_busy(busy), .o_err(err)
    );

    function automatic cloud_t cloud_of(input logic [HW-1:0] x, input logic [VW-1:0] y,
                                        input logic [DW-1:0] d);
        cloud_t c;
        c.x = CW'(x) * CW'(3) + CW'(d);
        c.y = CW'(y) ^ (CW'(d) << 4);
        c.z = CW'(d) * CW'(5) + CW'(x);
        return c;
    endfunction

    // Idx2Cloud stand-in: no reset, no stall, fixed LATENCY.
    logic          p_v [LATENCY] = '{default: 1'b0};
    logic [HW-1:0] p_x [LATENCY] = '{default: '0};
    logic [VW-1:0] p_y [LATENCY] = '{default: '0};
    logic [DW-1:0] p_d [LATENCY] = '{default: '0};

    always @(posedge clk) begin
        p_v[0] <= i2c_valid;
        p_x[0] <= i2c_x;
        p_y[0] <= i2c_y;
        p_d[0] <= i2c_d;
        for (int i = 1; i < int'(LATENCY); i++) begin
            p_v[i] <= p_v[i-1];
            p_x[i] <= p_x[i-1];
            p_y[i] <= p_y[i-1];
            p_d[i] <= p_d[i-1];
        end
    end

    assign ret_valid = p_v[LATENCY-1] | inj;
    assign ret_c     = inj ? inj_c : cloud_of(p_x[LATENCY-1], p_y[LATENCY-1], p_d[LATENCY-1]);

    // Reference state: outstanding = accepted non-zero samples not yet popped.
    sample_t       src0[$];
    sample_t       src1[$];
    exp_t          outq[$];
    int            outstanding = 0;
    int            drops = 0;
    int            cyc = 0;
    logic          rr = 1'b0;
    logic          exp_i2c_v = 1'b0;
    sample_t       exp_i2c_s = '0;
    int unsigned   vprob = 100;
    int unsigned   rprob = 100;
    int            pop_tag_cnt [2] = '{0, 0};
    int            acc_obs = 0;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic sample_t rand_sample(input int unsigned zero_pct);
        sample_t s;
        s.x = HW'($urandom);
        s.y = VW'($urandom);
        s.d = ($urandom_range(99) < zero_pct) ? '0 : DW'($urandom_range(1, 65535));
        return s;
    endfunction

    // One clock cycle: drive at the falling edge, check, then advance the reference.
    task automatic step();
        sample_t s0, s1, s;
        logic    v0, v1, win, exp_ov;
        logic [1:0] exp_rdy;
        exp_t    e;
        v0 = (src0.size() != 0) && ($urandom_range(99) < vprob);
        v1 = (src1.size() != 0) && ($urandom_range(99) < vprob);
        s0 = v0 ? src0[0] : '0;
        s1 = v1 ? src1[0] : '0;
        req_valid = {v1, v0};
        r0_x = s0.x; r0_y = s0.y; r0_d = s0.d;
        r1_x = s1.x; r1_y = s1.y; r1_d = s1.d;
        rdy_in = ($urandom_range(99) < rprob);
        #1;
        win = (v0 && v1) ? rr : v1;
        exp_rdy = ((v0 || v1) && outstanding < int'(FIFO_DEPTH)) ? (win ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if ((req_ready & req_valid) != 2'b00) acc_obs++;
        exp_ov = (outq.size() != 0) && (outq[0].t_vis <= cyc);
        chk("o_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) begin
            chk("o_tag", 32'(out_tag), 32'(outq[0].tag));
            chk("o_cloud_x", 32'(out_x), 32'(outq[0].c.x));
            chk("o_cloud_y", 32'(out_y), 32'(outq[0].c.y));
            chk("o_cloud_z", 32'(out_z), 32'(outq[0].c.z));
        end
        chk("i2c_valid", 32'(i2c_valid), 32'(exp_i2c_v));
        if (exp_i2c_v) begin
            chk("i2c_depth", 32'(i2c_d), 32'(exp_i2c_s.d));
            chk("i2c_idx_x", 32'(i2c_x), 32'(exp_i2c_s.x));
            chk("i2c_idx_y", 32'(i2c_y), 32'(exp_i2c_s.y));
        end
        chk("drop_cnt", 32'(drop_cnt), 32'(drops));
        chk("err", 32'(err), 32'd0);
        chk("busy", 32'(busy), 32'(outstanding != 0));
        if (out_valid && rdy_in) pop_tag_cnt[out_tag]++;
        if (exp_ov && rdy_in) begin
            void'(outq.pop_front());
            outstanding--;
        end
        exp_i2c_v = 1'b0;
        if (exp_rdy != 2'b00) begin
            s = win ? src1.pop_front() : src0.pop_front();
            rr = ~win;
            if (s.d == '0) begin
                if (drops < 65535) drops++;
            end else begin
                e.tag = win;
                e.c = cloud_of(s.x, s.y, s.d);
                e.t_vis = cyc + int'(LATENCY) + 2;
                outq.push_back(e);
                outstanding++;
                exp_i2c_v = 1'b1;
                exp_i2c_s = s;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        vprob = 100;
        rprob = 100;
        while ((src0.size() != 0 || src1.size() != 0 || outq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        step();
        chk("drained_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        sample_t s;
        // Reset values, with ready forced low while reset is asserted.
        repeat (6) @(negedge clk);
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_o_valid", 32'(out_valid), 32'd0);
        chk("rst_i2c_valid", 32'(i2c_valid), 32'd0);
        chk("rst_i2c_depth", 32'(i2c_d), 32'd0);
        chk("rst_o_tag", 32'(out_tag), 32'd0);
        chk("rst_o_cloud_x", 32'(out_x), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, depths 100..119.
        for (int i = 0; i < 20; i++) begin
            s = rand_sample(0);
            s.d = DW'(100 + i);
            src0.push_back(s);
        end
        pop_tag_cnt = '{0, 0};
        drain(200);
        chk("single_tag0_count", 32'(pop_tag_cnt[0]), 32'd20);

        // Both requesters held valid: strict alternation.
        for (int i = 0; i < 8; i++) begin
            src0.push_back(rand_sample(0));
            src1.push_back(rand_sample(0));
        end
        pop_tag_cnt = '{0, 0};
        drain(200);
        chk("alt_tag0_count", 32'(pop_tag_cnt[0]), 32'd8);
        chk("alt_tag1_count", 32'(pop_tag_cnt[1]), 32'd8);

        // Backpressure: credits stop acceptance at FIFO_DEPTH.
        for (int i = 0; i < 10; i++) begin
            src0.push_back(rand_sample(0));
            src1.push_back(rand_sample(0));
        end
        vprob = 100;
        rprob = 0;
        acc_obs = 0;
        repeat (20) step();
        chk("bp_accepts", 32'(acc_obs), 32'(FIFO_DEPTH));
        req_valid = 2'b11;
        #1;
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        drain(200);

        // Zero-depth samples are consumed, counted and still rotate the pointer.
        foreach (src1[i]) ;
        for (int i = 0; i < 4; i++) begin
            s = rand_sample(0);
            s.d = (i % 2 == 0) ? DW'(0) : DW'(5 + 2 * (i / 2));
            src1.push_back(s);
            src0.push_back(rand_sample(0));
        end
        pop_tag_cnt = '{0, 0};
        drain(200);
        chk("zero_drop_cnt", 32'(drop_cnt), 32'd2);
        chk("zero_tag1_count", 32'(pop_tag_cnt[1]), 32'd2);
        chk("zero_tag0_count", 32'(pop_tag_cnt[0]), 32'd4);

        // Random traffic with random backpressure and zero depths.
        vprob = 75;
        rprob = 60;
        for (int i = 0; i < 1500; i++) begin
            if (src0.size() < 3) src0.push_back(rand_sample(20));
            if (src1.size() < 3) src1.push_back(rand_sample(20));
            step();
        end
        drain(400);

        // Spurious return: sticky error, pushed with tag 0.
        req_valid = 2'b00;
        rdy_in = 1'b0;
        inj_c = '{x: CW'(24'h0A5A5A), y: CW'(24'h123456), z: CW'(24'h00BEEF)};
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        #1;
        chk("spur_err", 32'(err), 32'd1);
        chk("spur_o_valid", 32'(out_valid), 32'd1);
        chk("spur_o_tag", 32'(out_tag), 32'd0);
        chk("spur_o_cloud_x", 32'(out_x), 32'h0A5A5A);
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);

        // Reset with three samples in flight: stale returns must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 2'b01;
            r0_x = HW'(i + 1);
            r0_y = VW'(i + 2);
            r0_d = DW'(300 + i);
            #1;
            chk("pre_rst_ready", 32'(req_ready), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("rst_ready_forced", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("post_rst_o_valid", 32'(out_valid), 32'd0);
            chk("post_rst_err", 32'(err), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_drop", 32'(drop_cnt), 32'd0);
            chk("post_rst_i2c_valid", 32'(i2c_valid), 32'd0);
            @(negedge clk);
        end
        src0.delete();
        src1.delete();
        outq.delete();
        outstanding = 0;
        drops = 0;
        rr = 1'b0;
        exp_i2c_v = 1'b0;

        // Normal operation resumes after reset.
        vprob = 80;
        rprob = 70;
        for (int i = 0; i < 300; i++) begin
            if (src0.size() < 3) src0.push_back(rand_sample(15));
            if (src1.size() < 3) src1.push_back(rand_sample(15));
            step();
        end
        drain(400);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
